if_fetch_stage: RTL and testbench

- Fetch stage downstream of the next-PC selector: holds the architectural fetch PC and drives it back as curr_pc.
- Issues one instruction-memory request per PC.
- Presents fetched instruction plus its PC to decode through a valid/ready IF/ID register.
- Honours pipelineFlush by redirecting to next_pc and discarding any stale in-flight or held instruction.

---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 tb/tb_if_fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the IF/ID valid/ready slot.
// master is the fetch stage; slave is the memory/decode side.
interface if_fetch_stage_if #(
  parameter int INST_WIDTH = 32
);
  logic                  imem_req;
  logic [INST_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  id_valid;
  logic                  id_ready;
  logic [INST_WIDTH-1:0] id_inst;
  logic [INST_WIDTH-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one memory request per PC, result held in a valid/ready IF/ID slot.
// Optional IF_MISALIGN_TRAP_EN adds a sticky fetch_misalign trap on misaligned PC loads.
module if_fetch_stage #(
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] RESET_PC   = {INST_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [INST_WIDTH-1:0] next_pc,
  input  logic                  pipelineFlush,
  output logic [INST_WIDTH-1:0] curr_pc,
  if_fetch_stage_if.master      bus
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t state;
  logic   discard;
  logic   flush;
  logic   load_pc;
  logic   trap;
  logic   stall;

  assign flush         = pipelineFlush & start;
  assign load_pc       = flush | ((state == HOLD) & bus.id_ready);
  assign bus.imem_addr = curr_pc;

`ifdef IF_MISALIGN_TRAP_EN
  assign trap  = load_pc & (next_pc[1:0] != 2'b00);
  assign stall = fetch_misalign;
`else
  assign trap  = 1'b0;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      curr_pc      <= RESET_PC;
      bus.imem_req <= 1'b0;
      bus.id_valid <= 1'b0;
      bus.id_inst  <= '0;
      bus.id_pc    <= '0;
      discard      <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      if (load_pc) curr_pc <= next_pc;

      case (state)
        IDLE: begin
          if (start && !stall) begin
            state        <= REQ;
            bus.imem_req <= 1'b1;
          end
        end

        REQ: begin
          // A grant coinciding with a flush belongs to the old PC: its data must be dropped.
          if (flush) begin
            if (bus.imem_gnt) begin
              discard      <= 1'b1;
              state        <= WAIT;
              bus.imem_req <= 1'b0;
            end
          end else if (bus.imem_gnt) begin
            state        <= WAIT;
            bus.imem_req <= 1'b0;
          end else if (!start) begin
            state        <= IDLE;
            bus.imem_req <= 1'b0;
          end
        end

        WAIT: begin
          // A response landing on the flush edge is stale, so it is dropped without arming discard.
          if (bus.imem_rvalid) begin
            if (discard || flush) begin
              discard      <= 1'b0;
              state        <= start ? REQ : IDLE;
              bus.imem_req <= start;
            end else begin
              bus.id_inst  <= bus.imem_rdata;
              bus.id_pc    <= curr_pc;
              bus.id_valid <= 1'b1;
              state        <= HOLD;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end

        HOLD: begin
          if (flush) begin
            bus.id_valid <= 1'b0;
            state        <= REQ;
            bus.imem_req <= 1'b1;
          end else if (bus.id_ready) begin
            bus.id_valid <= 1'b0;
            state        <= start ? REQ : IDLE;
            bus.imem_req <= start;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef IF_MISALIGN_TRAP_EN
      // Misaligned PC load parks the stage; any in-flight response is then ignored in IDLE.
      if (trap) begin
        fetch_misalign <= 1'b1;
        state          <= IDLE;
        bus.imem_req   <= 1'b0;
        discard        <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table of per-cycle inputs/expected registered outputs,
// plus a hand-written grant-to-valid latency and throughput sequence.
module tb_if_fetch_stage;
  localparam int W = 32;

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         pipelineFlush;
  logic [W-1:0] next_pc;
  logic [W-1:0] curr_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic         fetch_misalign;
`endif

  if_fetch_stage_if #(.INST_WIDTH(W)) bus ();

  if_fetch_stage #(.INST_WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .next_pc      (next_pc),
    .pipelineFlush(pipelineFlush),
    .curr_pc      (curr_pc),
    .bus          (bus)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rn, st, fl, g, rv, rdy;
    logic [W-1:0] np, rdt;
    logic [W-1:0] e_pc;
    logic         e_req, e_vld;
    logic [W-1:0] e_inst, e_idpc;
    logic         e_mis;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic rn, st, fl, g, rv, rdy,
                              input logic [W-1:0] np, rdt, epc,
                              input logic ereq, evld,
                              input logic [W-1:0] einst, eidpc,
                              input logic emis);
    vec_t v;
    v.rn = rn; v.st = st; v.fl = fl; v.g = g; v.rv = rv; v.rdy = rdy;
    v.np = np; v.rdt = rdt; v.e_pc = epc; v.e_req = ereq; v.e_vld = evld;
    v.e_inst = einst; v.e_idpc = eidpc; v.e_mis = emis;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [W-1:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic rn, st, fl, g, rv, rdy, input logic [W-1:0] np, rdt);
    rst_n           = rn;
    start           = st;
    pipelineFlush   = fl;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.id_ready    = rdy;
    next_pc         = np;
    bus.imem_rdata  = rdt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; pipelineFlush = 1'b0; next_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;

    //          rn st fl g rv rdy np            rdata           | pc            req vld inst            idpc        mis
    // reset and first fetch
    tbl.push_back(mk(0,0,0,0,0,0, 32'h4,   32'h0,        32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h4,   32'h0,        32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,1,0,0,0,1, 32'h4,   32'h0,        32'h0,   1,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,1,0,1,0,1, 32'h4,   32'h0,        32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,1,0,0,1,1, 32'h4,   32'h00500093, 32'h0,   0,1, 32'h00500093, 32'h0,  0));
    tbl.push_back(mk(1,1,0,0,0,1, 32'h4,   32'h0,        32'h4,   1,0, 32'h00500093, 32'h0,  0));
    // decode stall in HOLD for 5 cycles, with a stray rvalid/gnt
    tbl.push_back(mk(1,1,0,1,0,0, 32'h8,   32'h0,        32'h4,   0,0, 32'h00500093, 32'h0,  0));
    tbl.push_back(mk(1,1,0,0,1,0, 32'h8,   32'h00208113, 32'h4,   0,1, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h8,   32'h0,        32'h4,   0,1, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h8,   32'h0,        32'h4,   0,1, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,1,1,0, 32'h8,   32'hDEADBEEF, 32'h4,   0,1, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h8,   32'h0,        32'h4,   0,1, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h8,   32'h0,        32'h4,   0,1, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,0,1, 32'h8,   32'h0,        32'h8,   1,0, 32'h00208113, 32'h4,  0));
    // flush while waiting on PC 8
    tbl.push_back(mk(1,1,0,1,0,0, 32'h8,   32'h0,        32'h8,   0,0, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,1,0,0,0, 32'h40,  32'h0,        32'h40,  0,0, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,1,0, 32'h40,  32'h11111111, 32'h40,  1,0, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,1,0,0, 32'h40,  32'h0,        32'h40,  0,0, 32'h00208113, 32'h4,  0));
    tbl.push_back(mk(1,1,0,0,1,0, 32'h44,  32'h00000013, 32'h40,  0,1, 32'h00000013, 32'h40, 0));
    tbl.push_back(mk(1,1,0,0,0,1, 32'h44,  32'h0,        32'h44,  1,0, 32'h00000013, 32'h40, 0));
    // flush coincident with grant
    tbl.push_back(mk(1,1,1,1,0,0, 32'h80,  32'h0,        32'h80,  0,0, 32'h00000013, 32'h40, 0));
    tbl.push_back(mk(1,1,0,0,1,0, 32'h80,  32'h22222222, 32'h80,  1,0, 32'h00000013, 32'h40, 0));
    tbl.push_back(mk(1,1,0,1,0,0, 32'h80,  32'h0,        32'h80,  0,0, 32'h00000013, 32'h40, 0));
    tbl.push_back(mk(1,1,0,0,1,0, 32'h80,  32'h33333333, 32'h80,  0,1, 32'h33333333, 32'h80, 0));
    // flush with handshake in HOLD, then flush of ungranted REQ
    tbl.push_back(mk(1,1,1,0,0,1, 32'h100, 32'h0,        32'h100, 1,0, 32'h33333333, 32'h80, 0));
    tbl.push_back(mk(1,1,1,0,0,0, 32'h200, 32'h0,        32'h200, 1,0, 32'h33333333, 32'h80, 0));
    tbl.push_back(mk(1,1,0,1,0,0, 32'h200, 32'h0,        32'h200, 0,0, 32'h33333333, 32'h80, 0));
    // reset in WAIT, stray rvalid after release
    tbl.push_back(mk(0,1,0,0,0,0, 32'h200, 32'h0,        32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,0,0,0,1,0, 32'h200, 32'h44444444, 32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h200, 32'h0,        32'h0,   1,0, 32'h0,        32'h0,  0));
    // start deassert in REQ, then in WAIT/HOLD
    tbl.push_back(mk(1,0,0,0,0,0, 32'h200, 32'h0,        32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h200, 32'h0,        32'h0,   1,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,1,0,1,0,0, 32'h200, 32'h0,        32'h0,   0,0, 32'h0,        32'h0,  0));
    tbl.push_back(mk(1,0,0,0,1,0, 32'h10,  32'h55555555, 32'h0,   0,1, 32'h55555555, 32'h0,  0));
    tbl.push_back(mk(1,0,0,0,0,1, 32'h10,  32'h0,        32'h10,  0,0, 32'h55555555, 32'h0,  0));
    tbl.push_back(mk(1,0,0,0,0,0, 32'h10,  32'h0,        32'h10,  0,0, 32'h55555555, 32'h0,  0));
    // misaligned flush target from IDLE
    tbl.push_back(mk(1,1,1,0,0,0, 32'h42,  32'h0,        32'h42,  !MIS,0, 32'h55555555, 32'h0, MIS));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h42,  32'h0,        32'h42,  !MIS,0, 32'h55555555, 32'h0, MIS));

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].st, tbl[i].fl, tbl[i].g, tbl[i].rv, tbl[i].rdy, tbl[i].np, tbl[i].rdt);
      chk("curr_pc",   i, curr_pc,       tbl[i].e_pc);
      chk("imem_addr", i, bus.imem_addr, tbl[i].e_pc);
      chk("imem_req",  i, W'(bus.imem_req), W'(tbl[i].e_req));
      chk("id_valid",  i, W'(bus.id_valid), W'(tbl[i].e_vld));
      chk("id_inst",   i, bus.id_inst,   tbl[i].e_inst);
      chk("id_pc",     i, bus.id_pc,     tbl[i].e_idpc);
`ifdef IF_MISALIGN_TRAP_EN
      chk("fetch_misalign", i, W'(fetch_misalign), W'(tbl[i].e_mis));
`endif
    end

    // grant-to-valid latency: response k cycles after the grant cycle -> id_valid k+1 cycles after it
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      step(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
      step(1, 1, 0, 1, 0, 0, 32'h0, 32'h0);
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        step(1, 1, 0, 0, (c == k), 0, 32'h0, 32'hA000_0000 | k);
        if (bus.id_valid) begin
          lat = c + 1;
          break;
        end
      end
      chk("latency", k, lat, k + 1);
      chk("lat_inst", k, bus.id_inst, 32'hA000_0000 | k);
    end

    // back-to-back best-case fetch: consume, grant, respond -> next instruction 3 cycles later
    step(1, 1, 0, 0, 0, 1, 32'hC, 32'h0);
    chk("tp_req", 0, W'(bus.imem_req), 32'h1);
    step(1, 1, 0, 1, 0, 0, 32'hC, 32'h0);
    chk("tp_vld_gap", 1, W'(bus.id_valid), 32'h0);
    step(1, 1, 0, 0, 1, 0, 32'hC, 32'h0BAD_F00D);
    chk("tp_vld", 2, W'(bus.id_valid), 32'h1);
    chk("tp_idpc", 2, bus.id_pc, 32'hC);
    chk("tp_inst", 2, bus.id_inst, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
